// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller and its counters.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } hz_state_e;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         CNT_W_DEF   = 16;
    localparam int         MUL_LAT_DEF = 4;

    // Load-use: a load in EX writes a register the ID instruction is about to read.
    function automatic logic load_use(
        input logic       ex_mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       id_uses_rt
    );
        return ex_mem_read && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count events, holding once the top value is reached.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= {WIDTH{1'b0}};
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall / branch-flush controller for the 5-stage MIPS pipeline.
// Define PIPE_MULDIV_STALL_EN to add the multi-cycle multiply stall (idMulStart, mulBusy, MUL_WAIT).
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF
`ifdef PIPE_MULDIV_STALL_EN
    ,
    parameter int MUL_LAT = MUL_LAT_DEF
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       idRs,
    input  logic [4:0]       idRt,
    input  logic             idUsesRt,
    input  logic [4:0]       exRt,
    input  logic             exMemRead,
    input  logic             memBranchTaken,
`ifdef PIPE_MULDIV_STALL_EN
    input  logic             idMulStart,
    output logic             mulBusy,
`endif
    output logic             pcWrite,
    output logic             ifIdWrite,
    output logic             ifIdFlush,
    output logic             idExFlush,
    output logic             exMemFlush,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    logic lu_s;
    logic stall_inc_s;
    logic flush_inc_s;

    assign lu_s = load_use(exMemRead, exRt, idRs, idRt, idUsesRt);

`ifdef PIPE_MULDIV_STALL_EN
    localparam int              MC_W       = $clog2(MUL_LAT) + 1;
    localparam logic [MC_W-1:0] MUL_CNT_LD = MC_W'(MUL_LAT - 1);
    localparam logic [MC_W-1:0] MUL_CNT_1  = MC_W'(1);

    hz_state_e       state_r;
    logic [MC_W-1:0] mul_cnt_r;

    // Multiply sequencer: a branch flush aborts the wait, otherwise count down to the last stall cycle.
    always_ff @(posedge clk) begin
        if (reset || memBranchTaken) begin
            state_r   <= RUN;
            mul_cnt_r <= {MC_W{1'b0}};
        end else begin
            case (state_r)
                RUN: begin
                    if (idMulStart && !lu_s) begin
                        state_r   <= MUL_WAIT;
                        mul_cnt_r <= MUL_CNT_LD;
                    end else begin
                        state_r   <= RUN;
                        mul_cnt_r <= mul_cnt_r;
                    end
                end
                MUL_WAIT: begin
                    mul_cnt_r <= mul_cnt_r - MUL_CNT_1;
                    if (mul_cnt_r == MUL_CNT_1) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= MUL_WAIT;
                    end
                end
                default: begin
                    state_r   <= RUN;
                    mul_cnt_r <= {MC_W{1'b0}};
                end
            endcase
        end
    end
`endif

    // Mealy control decode in priority order: reset, flush, multiply wait, load-use, normal.
    always_comb begin
        pcWrite     = 1'b1;
        ifIdWrite   = 1'b1;
        ifIdFlush   = 1'b0;
        idExFlush   = 1'b0;
        exMemFlush  = 1'b0;
        stall_inc_s = 1'b0;
        flush_inc_s = 1'b0;
`ifdef PIPE_MULDIV_STALL_EN
        mulBusy     = 1'b0;
`endif
        if (reset) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            ifIdFlush  = 1'b1;
            idExFlush  = 1'b1;
            exMemFlush = 1'b1;
        end else if (memBranchTaken) begin
            ifIdFlush   = 1'b1;
            idExFlush   = 1'b1;
            exMemFlush  = 1'b1;
            flush_inc_s = 1'b1;
`ifdef PIPE_MULDIV_STALL_EN
        end else if (state_r == MUL_WAIT) begin
            pcWrite     = 1'b0;
            ifIdWrite   = 1'b0;
            idExFlush   = 1'b1;
            mulBusy     = 1'b1;
            stall_inc_s = 1'b1;
`endif
        end else if (lu_s) begin
            pcWrite     = 1'b0;
            ifIdWrite   = 1'b0;
            idExFlush   = 1'b1;
            stall_inc_s = 1'b1;
        end else begin
            pcWrite   = 1'b1;
            ifIdWrite = 1'b1;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc_s),
        .count (stallCount)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc_s),
        .count (flushCount)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; a second instance with 2-bit counters covers saturation.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  idRs, idRt, exRt;
    logic        idUsesRt, exMemRead, memBranchTaken;
    logic        idMulStart;
    logic        mulBusy, mulBusy_small;
    logic        pcWrite, ifIdWrite, ifIdFlush, idExFlush, exMemFlush;
    logic        pcWrite_s2, ifIdWrite_s2, ifIdFlush_s2, idExFlush_s2, exMemFlush_s2;
    logic [15:0] stallCount, flushCount;
    logic [1:0]  stallCount_small, flushCount_small;
    logic [4:0]  ctl;

    int checks   = 0;
    int failures = 0;

    localparam logic [4:0] CTL_RESET  = 5'b00111;
    localparam logic [4:0] CTL_NORMAL = 5'b11000;
    localparam logic [4:0] CTL_STALL  = 5'b00010;
    localparam logic [4:0] CTL_FLUSH  = 5'b11111;

    assign ctl = {pcWrite, ifIdWrite, ifIdFlush, idExFlush, exMemFlush};

    always #5 clk = ~clk;

    hazard_ctrl #(
        .CNT_W(16)
`ifdef PIPE_MULDIV_STALL_EN
        , .MUL_LAT(4)
`endif
    ) dut (
        .clk(clk), .reset(reset), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
        .exRt(exRt), .exMemRead(exMemRead), .memBranchTaken(memBranchTaken),
`ifdef PIPE_MULDIV_STALL_EN
        .idMulStart(idMulStart), .mulBusy(mulBusy),
`endif
        .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .ifIdFlush(ifIdFlush),
        .idExFlush(idExFlush), .exMemFlush(exMemFlush),
        .stallCount(stallCount), .flushCount(flushCount)
    );

    hazard_ctrl #(
        .CNT_W(2)
`ifdef PIPE_MULDIV_STALL_EN
        , .MUL_LAT(4)
`endif
    ) dut_small (
        .clk(clk), .reset(reset), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
        .exRt(exRt), .exMemRead(exMemRead), .memBranchTaken(memBranchTaken),
`ifdef PIPE_MULDIV_STALL_EN
        .idMulStart(idMulStart), .mulBusy(mulBusy_small),
`endif
        .pcWrite(pcWrite_s2), .ifIdWrite(ifIdWrite_s2), .ifIdFlush(ifIdFlush_s2),
        .idExFlush(idExFlush_s2), .exMemFlush(exMemFlush_s2),
        .stallCount(stallCount_small), .flushCount(flushCount_small)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        idRs = 5'd0; idRt = 5'd0; idUsesRt = 1'b0; exRt = 5'd0;
        exMemRead = 1'b0; memBranchTaken = 1'b0; idMulStart = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_RESET) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, CTL_RESET); end
        cyc();
        cyc();
        checks++;
        if (stallCount !== 16'd0 || flushCount !== 16'd0) begin
            failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", stallCount, flushCount);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (ctl !== CTL_NORMAL) begin failures++; $display("FAIL normal_ctl got=%b exp=%b", ctl, CTL_NORMAL); end
        cyc();
    endtask

    task automatic test_lu_rs();
        exMemRead = 1'b1; exRt = 5'd8; idRs = 5'd8; idRt = 5'd2;
        #1;
        checks++;
        if (ctl !== CTL_STALL) begin failures++; $display("FAIL lu_rs_ctl got=%b exp=%b", ctl, CTL_STALL); end
        checks++;
        if (stallCount !== 16'd0) begin failures++; $display("FAIL lu_rs_pre_cnt got=%0d exp=0", stallCount); end
        cyc();
        idle();
        #1;
        checks++;
        if (stallCount !== 16'd1) begin failures++; $display("FAIL lu_rs_cnt got=%0d exp=1", stallCount); end
        checks++;
        if (ctl !== CTL_NORMAL) begin failures++; $display("FAIL lu_rs_after got=%b exp=%b", ctl, CTL_NORMAL); end
    endtask

    task automatic test_reg_zero();
        exMemRead = 1'b1; exRt = 5'd0; idRs = 5'd0; idRt = 5'd0; idUsesRt = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_NORMAL) begin failures++; $display("FAIL reg_zero_ctl got=%b exp=%b", ctl, CTL_NORMAL); end
        cyc();
        idle();
        checks++;
        if (stallCount !== 16'd1) begin failures++; $display("FAIL reg_zero_cnt got=%0d exp=1", stallCount); end
    endtask

    task automatic test_rt_match();
        exMemRead = 1'b1; exRt = 5'd9; idRt = 5'd9; idRs = 5'd3; idUsesRt = 1'b0;
        #1;
        checks++;
        if (ctl !== CTL_NORMAL) begin failures++; $display("FAIL rt_unused_ctl got=%b exp=%b", ctl, CTL_NORMAL); end
        cyc();
        checks++;
        if (stallCount !== 16'd1) begin failures++; $display("FAIL rt_unused_cnt got=%0d exp=1", stallCount); end
        idUsesRt = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_STALL) begin failures++; $display("FAIL rt_used_ctl got=%b exp=%b", ctl, CTL_STALL); end
        cyc();
        idle();
        checks++;
        if (stallCount !== 16'd2) begin failures++; $display("FAIL rt_used_cnt got=%0d exp=2", stallCount); end
    endtask

    task automatic test_flush_beats_lu();
        exMemRead = 1'b1; exRt = 5'd8; idRs = 5'd8; memBranchTaken = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_FLUSH) begin failures++; $display("FAIL flush_ctl got=%b exp=%b", ctl, CTL_FLUSH); end
        cyc();
        idle();
        checks++;
        if (stallCount !== 16'd2 || flushCount !== 16'd1) begin
            failures++; $display("FAIL flush_cnts got=%0d/%0d exp=2/1", stallCount, flushCount);
        end
    endtask

    task automatic test_saturation();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        exMemRead = 1'b1; exRt = 5'd4; idRs = 5'd4;
        for (int n = 1; n <= 5; n++) begin
            cyc();
            checks++;
            if (stallCount_small !== ((n > 3) ? 2'd3 : 2'(n))) begin
                failures++; $display("FAIL sat_cnt_%0d got=%0d exp=%0d", n, stallCount_small, (n > 3) ? 3 : n);
            end
        end
        idle();
        checks++;
        if (stallCount !== 16'd5) begin failures++; $display("FAIL sat_wide_cnt got=%0d exp=5", stallCount); end
    endtask

`ifdef PIPE_MULDIV_STALL_EN
    task automatic test_multiply();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        idMulStart = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_NORMAL || mulBusy !== 1'b0) begin
            failures++; $display("FAIL mul_issue got=%b/%b exp=%b/0", ctl, mulBusy, CTL_NORMAL);
        end
        cyc();
        idMulStart = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ctl !== CTL_STALL || mulBusy !== 1'b1) begin
                failures++; $display("FAIL mul_wait_%0d got=%b/%b exp=%b/1", k, ctl, mulBusy, CTL_STALL);
            end
            cyc();
        end
        checks++;
        if (ctl !== CTL_NORMAL || mulBusy !== 1'b0 || stallCount !== 16'd3) begin
            failures++; $display("FAIL mul_done got=%b/%b/%0d exp=%b/0/3", ctl, mulBusy, stallCount, CTL_NORMAL);
        end
    endtask

    task automatic test_mul_abort();
        idMulStart = 1'b1;
        cyc();
        idMulStart = 1'b0;
        cyc();
        memBranchTaken = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_FLUSH) begin failures++; $display("FAIL mul_abort_ctl got=%b exp=%b", ctl, CTL_FLUSH); end
        cyc();
        memBranchTaken = 1'b0;
        #1;
        checks++;
        if (mulBusy !== 1'b0 || ctl !== CTL_NORMAL) begin
            failures++; $display("FAIL mul_abort_after got=%b/%b exp=0/%b", mulBusy, ctl, CTL_NORMAL);
        end
        checks++;
        if (stallCount !== 16'd4 || flushCount !== 16'd1) begin
            failures++; $display("FAIL mul_abort_cnts got=%0d/%0d exp=4/1", stallCount, flushCount);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lu_rs();
        test_reg_zero();
        test_rt_match();
        test_flush_beats_lu();
        test_saturation();
`ifdef PIPE_MULDIV_STALL_EN
        test_multiply();
        test_mul_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
